engine_clause_queue: RTL

- Receiving end of the clause-distribution interface; one instance per engine.
- Accepts clauses on the arbiter's per-engine clause/grant pair and buffers them in a FIFO.
- Returns the per-engine full signal the arbiter treats as the inverse of a request.
- Presents buffered clauses to the engine's BCP core over a valid/ready dequeue port, and supports a one-cycle flush on conflict/backtrack.

---
 rtl/engine_clause_queue_pkg.sv | 34 +++
 rtl/engine_clause_queue_occupancy_ctrl.sv | 87 ++++++++
 rtl/engine_clause_queue.sv | 70 +++++++
 3 files changed

// File: rtl/engine_clause_queue_pkg.sv
// Shared clause types and queue sizing helpers for the per-engine clause queue.
// Optional feature macro used by the queue: ENGINE_CLAUSE_QUEUE_BYPASS_EN.
package engine_clause_queue_pkg;

    localparam int NUM_ENGINE  = 4;
    localparam int LIT_IDX_MAX = 255;

    // Literal: sign bit above the variable index.
    typedef struct packed {
        logic                           sign;
        logic [$clog2(LIT_IDX_MAX+1)-1:0] idx;
    } lit_t;

    // Clause of up to three literals; len gives how many are meaningful.
    typedef struct packed {
        logic [1:0] len;
        lit_t       lit2;
        lit_t       lit1;
        lit_t       lit0;
    } cla_t;

    localparam int QUEUE_DEPTH_DEFAULT = 16;
    localparam int QUEUE_SLACK_DEFAULT = 2;

    // Occupancy counter width for the default depth (holds 0..DEPTH inclusive).
    localparam int COUNT_W = $clog2(QUEUE_DEPTH_DEFAULT) + 1;
    typedef logic [COUNT_W-1:0] count_t;

    // Occupancy at which full is raised toward the arbiter.
    function automatic int full_threshold(input int depth, input int slack);
        return depth - slack;
    endfunction

endpackage

// File: rtl/engine_clause_queue_occupancy_ctrl.sv
// Occupancy controller: pointers, count, push/pop/flush arbitration and
// full/empty/overflow status. With ENGINE_CLAUSE_QUEUE_BYPASS_EN a grant into
// an empty queue that is consumed in the same cycle is neither written nor counted.
module queue_occupancy_ctrl
    import engine_clause_queue_pkg::*;
#(
    parameter int DEPTH      = QUEUE_DEPTH_DEFAULT,
    parameter int FULL_SLACK = QUEUE_SLACK_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       grant,
    input  logic                       flush,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic                       fifo_valid,
    output logic                       overflow_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_TH_C = CW'(full_threshold(DEPTH, FULL_SLACK));

    logic          push;
    logic          pop;
    logic          drop;
    logic          bypass_hit;
    logic [CW-1:0] count_next;

    // Decide push/pop/drop for this cycle and the resulting occupancy.
    always_comb begin
        pop        = (count != '0) && deq_ready;
        bypass_hit = 1'b0;
`ifdef ENGINE_CLAUSE_QUEUE_BYPASS_EN
        bypass_hit = (count == '0) && grant && deq_ready && !flush;
`endif
        // A pop in the same cycle frees the slot a grant at DEPTH needs.
        push       = grant && ((count != DEPTH_C) || pop) && !bypass_hit;
        drop       = grant && (count == DEPTH_C) && !pop && !flush;
        wr_en      = push && !flush;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointer and count registers; flush overrides any same-cycle push or pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_err <= 1'b0;
        end else if (drop) begin
            overflow_err <= 1'b1;
        end
    end

    // Status decode from the registered count.
    always_comb begin
        full       = (count >= FULL_TH_C);
        empty      = (count == '0);
        fifo_valid = (count != '0);
    end

endmodule

// File: rtl/engine_clause_queue.sv
// Per-engine clause queue: buffers granted clauses from the arbiter and hands
// them to the BCP core over a valid/ready port. full_out throttles the arbiter.
// Optional macro ENGINE_CLAUSE_QUEUE_BYPASS_EN: a grant into an empty queue is
// presented on the dequeue port in the same cycle.
module engine_clause_queue
    import engine_clause_queue_pkg::*;
#(
    parameter int DEPTH      = QUEUE_DEPTH_DEFAULT,
    parameter int FULL_SLACK = QUEUE_SLACK_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  cla_t                     clause_in,
    input  logic                     grant_in,
    output logic                     full_out,
    input  logic                     flush_in,
    output cla_t                     deq_clause_out,
    output logic                     deq_valid_out,
    input  logic                     deq_ready_in,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_err_out
);

    logic [$clog2(DEPTH)-1:0] wr_ptr;
    logic [$clog2(DEPTH)-1:0] rd_ptr;
    logic                     wr_en;
    logic                     empty;
    logic                     fifo_valid;
    logic                     bypass_active;
    cla_t                     mem [DEPTH];

    queue_occupancy_ctrl #(
        .DEPTH      (DEPTH),
        .FULL_SLACK (FULL_SLACK)
    ) u_occ (
        .clock        (clock),
        .reset        (reset),
        .grant        (grant_in),
        .flush        (flush_in),
        .deq_ready    (deq_ready_in),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count_out),
        .wr_en        (wr_en),
        .full         (full_out),
        .empty        (empty),
        .fifo_valid   (fifo_valid),
        .overflow_err (overflow_err_out)
    );

    // Clause storage; contents are don't-care until written, reads are masked when empty.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= clause_in;
    end

    // Dequeue port: head of the FIFO, or the incoming clause when bypassing.
    always_comb begin
        bypass_active = 1'b0;
`ifdef ENGINE_CLAUSE_QUEUE_BYPASS_EN
        bypass_active = empty && grant_in && !flush_in;
`endif
        empty_out     = empty;
        deq_valid_out = fifo_valid || bypass_active;
        if (bypass_active)  deq_clause_out = clause_in;
        else if (fifo_valid) deq_clause_out = mem[rd_ptr];
        else                 deq_clause_out = '0;
    end

endmodule
